// File: rtl/scpad_rsv_arbiter_if.sv
// Reservation request/grant bundle shared by the scratchpad reservation arbiter and its clients.
// master drives requests/releases; slave (the arbiter) drives the grant-side signals.
interface scpad_rsv_arbiter_if #(
  parameter int unsigned N_REQ = 3
);
  localparam int unsigned IdW = $clog2(N_REQ);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] rel;
  logic [N_REQ-1:0] rsv;
  logic [IdW-1:0]   rsv_id;
  logic             busy;
  logic             timeout;
  logic [N_REQ-1:0] urgent;

  modport master (
    output req, rel,
    input  rsv, rsv_id, busy, timeout, urgent
  );

  modport slave (
    input  req, rel,
    output rsv, rsv_id, busy, timeout, urgent
  );
endinterface

// File: rtl/scpad_rsv_arbiter.sv
// Scratchpad reservation arbiter: fixed-priority single-holder grant with hold timeout.
// Optional request aging is compiled in when SCPAD_ARB_AGING_EN is defined.
module scpad_rsv_arbiter #(
  parameter int unsigned N_REQ     = 3,
  parameter int unsigned MAX_HOLD  = 64,
  parameter int unsigned AGE_LIMIT = 16
) (
  input logic                clk,
  input logic                rst,
  scpad_rsv_arbiter_if.slave bus
);
  localparam int unsigned IdW   = $clog2(N_REQ);
  localparam int unsigned HoldW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic [1:0] {StIdle, StHeld, StFlush} state_e;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] rsv_q, rsv_d;
  logic [IdW-1:0]   rsv_id_q, rsv_id_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [HoldW-1:0] hold_inc;

  logic [N_REQ-1:0] urgent_vec;
  logic [N_REQ-1:0] mask;
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] cand;
  logic [N_REQ-1:0] win_oh;
  logic [IdW-1:0]   win_id;
  logic             win_vld;
  logic             holder_rel;

  // The current holder never competes in its own release cycle.
  assign mask       = (state_q == StHeld) ? rsv_q : '0;
  assign eligible   = bus.req & ~mask;
  assign holder_rel = |(rsv_q & (bus.rel | ~bus.req));
  assign hold_inc   = hold_q + HoldW'(1);

  always_comb begin
    cand = eligible;
    if (|(eligible & urgent_vec)) begin
      cand = eligible & urgent_vec;
    end
  end

  always_comb begin
    win_oh  = '0;
    win_id  = '0;
    win_vld = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (cand[i] && !win_vld) begin
        win_oh[i] = 1'b1;
        win_id    = IdW'(i);
        win_vld   = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rsv_d     = rsv_q;
    rsv_id_d  = rsv_id_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle, StFlush: begin
        rsv_d    = win_oh;
        rsv_id_d = win_id;
        hold_d   = '0;
        state_d  = win_vld ? StHeld : StIdle;
      end
      StHeld: begin
        if (holder_rel) begin
          rsv_d    = win_oh;
          rsv_id_d = win_id;
          hold_d   = '0;
          state_d  = win_vld ? StHeld : StIdle;
        end else if ((MAX_HOLD != 0) && (hold_inc == HoldW'(MAX_HOLD))) begin
          rsv_d     = '0;
          rsv_id_d  = '0;
          hold_d    = '0;
          timeout_d = 1'b1;
          state_d   = StFlush;
        end else begin
          hold_d = hold_inc;
        end
      end
      default: begin
        rsv_d    = '0;
        rsv_id_d = '0;
        hold_d   = '0;
        state_d  = StIdle;
      end
    endcase
    busy_d = |rsv_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      rsv_q     <= '0;
      rsv_id_q  <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      rsv_q     <= rsv_d;
      rsv_id_q  <= rsv_id_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      hold_q    <= hold_d;
    end
  end

`ifdef SCPAD_ARB_AGING_EN
  localparam int unsigned AgeW = (AGE_LIMIT > 0) ? $clog2(AGE_LIMIT + 1) : 1;

  logic [AgeW-1:0]  age_q [N_REQ];
  logic [AgeW-1:0]  age_d [N_REQ];
  logic [N_REQ-1:0] urgent_q, urgent_d;

  // Waiting time restarts whenever the request drops or is about to be served.
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!bus.req[i] || rsv_d[i]) begin
        age_d[i] = '0;
      end else if (age_q[i] == AgeW'(AGE_LIMIT)) begin
        age_d[i] = age_q[i];
      end else begin
        age_d[i] = age_q[i] + AgeW'(1);
      end
      urgent_d[i] = (age_d[i] == AgeW'(AGE_LIMIT));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      urgent_q <= '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      urgent_q <= urgent_d;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end

  assign urgent_vec = urgent_q;
`else
  assign urgent_vec = '0;
`endif

  assign bus.rsv     = rsv_q;
  assign bus.rsv_id  = rsv_id_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;
  assign bus.urgent  = urgent_vec;
endmodule

// File: doc/scpad_rsv_arbiter.md
SCPAD_RSV_ARBITER -- requirements
Module: scpad_rsv_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3, meaning requester count (idx 0 = BE, 1 = VC, 2 = SA), legal range 2..8.
REQ-002 SHALL have parameter MAX_HOLD, default 64, meaning max consecutive held cycles before forced revoke; 0 disables the timeout.
REQ-003 SHALL have parameter AGE_LIMIT, default 16, meaning wait cycles before a requester becomes urgent.
REQ-004 SHALL have port clk  input  1  meaning the single clock, all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  meaning reset, synchronous and active-high.
REQ-006 SHALL have port req  input  N_REQ  meaning per-requester reservation request (level).
REQ-007 SHALL have port rel  input  N_REQ  meaning per-requester release pulse.
REQ-008 SHALL have port rsv  output  N_REQ  meaning one-hot reservation grant, held while reserved.
REQ-009 SHALL have port rsv_id  output  $clog2(N_REQ)  meaning index of current holder, 0 when none.
REQ-010 SHALL have port busy  output  1  meaning reservation held (rsv != 0).
REQ-011 SHALL have port timeout  output  1  meaning 1-cycle pulse on forced revoke.
REQ-012 SHALL have port urgent  output  N_REQ  meaning requester has reached AGE_LIMIT.

Function
REQ-013 SHALL implement states IDLE, HELD, FLUSH; all outputs registered.
REQ-014 SHALL, in IDLE with any eligible req high, grant the winner: rsv one-hot asserted the next cycle (latency 1), state -> HELD.
REQ-015 SHALL select the winner by fixed priority, lowest index wins, unless REQ-027 applies.
REQ-016 SHALL keep rsv/rsv_id stable in HELD until release, timeout or reset; other requests do not preempt.
REQ-017 SHALL treat rel[holder]=1 or req[holder]=0 as release; rel of a non-holder and rel in IDLE/FLUSH SHALL be ignored.
REQ-018 SHALL, on a release cycle, arbitrate among req with the releasing index masked; winner gets rsv next cycle (direct handoff, no bubble); no winner -> IDLE with rsv=0.
REQ-019 SHALL, when rel[holder] and req[holder] are both high in the same cycle, honour the release; the holder is eligible again from the following cycle.
REQ-020 SHALL count held cycles in a counter of width $clog2(MAX_HOLD+1), cleared on every new grant.
REQ-021 SHALL, when MAX_HOLD>0 and the count reaches MAX_HOLD with no release, deassert rsv next cycle, pulse timeout for that cycle, and enter FLUSH.
REQ-022 SHALL spend exactly one cycle in FLUSH with rsv=0, then arbitrate normally (revoked index eligible) per REQ-014.
REQ-023 SHALL give release priority over timeout when both occur in the same cycle (timeout not pulsed).
REQ-024 SHALL never assert more than one rsv bit; rsv_id SHALL match the set bit.

Reset
REQ-025 SHALL, on rst high at a clock edge (including mid-HELD or FLUSH), set state IDLE, rsv=0, rsv_id=0, busy=0, timeout=0, urgent=0, and clear all counters by the next edge.

Configuration
REQ-026 SHALL compile request aging when macro SCPAD_ARB_AGING_EN is defined: per-requester wait counters increment each cycle req high and not granted, saturate at AGE_LIMIT, and clear on grant or req low; urgent[i]=1 when counter[i]==AGE_LIMIT.
REQ-027 SHALL, with SCPAD_ARB_AGING_EN defined, let urgent requesters beat non-urgent ones (lowest urgent index among urgent wins); priority otherwise per REQ-015.
REQ-028 SHALL, without SCPAD_ARB_AGING_EN, omit the counters, tie urgent to 0, and use pure fixed priority.

Verification
REQ-029 SHALL cover: req=3'b110 in IDLE at cycle 0 -> rsv=3'b010, rsv_id=1 at cycle 1; rel=3'b010 at cycle 4 -> rsv=3'b100 at cycle 5.
REQ-030 SHALL cover: holder 0 (MAX_HOLD=4), req[0] held, no rel -> rsv=0 and timeout=1 four cycles after grant, 1 FLUSH cycle, then rsv=3'b001 regranted.
REQ-031 SHALL cover: rel=3'b001 and timeout coinciding for holder 0 -> timeout stays 0, next grant per REQ-018.
REQ-032 SHALL cover: rel=3'b100 while holder is 0 -> ignored, rsv stays 3'b001.
REQ-033 SHALL cover (aging, AGE_LIMIT=3): req[0] re-requested every release, req[2] waiting -> urgent[2]=1 after 3 cycles, next grant rsv=3'b100 despite req[0].
REQ-034 SHALL cover: rst=1 during HELD -> all outputs 0 at the next edge, first grant after deassert obeys REQ-014 latency.
